icache_resp: RTL and testbench

Direct-mapped instruction cache that acts as the responder on the fetch stage's instruction-memory port (`imem_*`). It returns a hit word combinationally in the same cycle the address is presented. On a miss it asserts stall and refills one full line from main memory through a single-request line interface. It sits between the fetch stage and the instruction-side main memory.

---
 rtl/icache_resp_pkg.sv | 20 ++
 rtl/icache_tag_array.sv | 47 ++++
 rtl/icache_resp.sv | 135 +++++++++++++
 tb/tb_icache_resp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_resp_pkg.sv
// Shared types and constants for the instruction cache responder.
package icache_resp_pkg;

  localparam int          INSTR_SIZE = 32;
  // addi x0, x0, 0: returned whenever no valid instruction is available.
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int ICACHE_LINES = 4;
  localparam int ICACHE_WORDS = 4;
  localparam int LINE_SIZE    = 32 * ICACHE_WORDS;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage: combinational lookup port plus a write/flush port.
module icache_tag_array
  import icache_resp_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int TAG_W = 26,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] i_lookup_idx,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_flush
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  // Valid bits: reset and flush clear everything; flush beats a coincident fill.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag storage: written on every fill, even one that a flush invalidates.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; the valid bits alone qualify them,
    // which keeps the array mappable to plain flops/RAM without reset fan-out.
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_lookup_idx] && (r_tag[i_lookup_idx] == i_lookup_tag);

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache answering the fetch stage's imem port,
// refilling whole lines from main memory on a miss.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter int LINES          = ICACHE_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [INSTR_SIZE-1:0]         imem_addr_i,
  input  logic                          imem_rd_wr_i,
  input  logic                          imem_op_en_i,
  output logic [INSTR_SIZE-1:0]         imem_rd_instr_o,
  output logic                          imem_miss_o,
  input  logic                          flush_i,
  output logic                          mem_req_o,
  output logic [INSTR_SIZE-1:0]         mem_addr_o,
  output logic                          mem_rd_wr_o,
  input  logic                          mem_ready_i,
  input  logic [32*WORDS_PER_LINE-1:0]  mem_rdata_i
);

  localparam int WS_W     = $clog2(WORDS_PER_LINE);
  localparam int WS_BITS  = (WS_W == 0) ? 1 : WS_W;
  localparam int IDX_W    = $clog2(LINES);
  localparam int IDX_LSB  = 2 + WS_W;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;
  localparam int TAG_W    = INSTR_SIZE - TAG_LSB;
  // Byte offset within a line; cleared to form the refill address.
  localparam logic [INSTR_SIZE-1:0] OFS_MASK = INSTR_SIZE'(4 * WORDS_PER_LINE - 1);

  icache_state_t r_state;
  icache_state_t w_next_state;

  logic [INSTR_SIZE-1:0] r_mem_addr;
  logic [31:0]           r_data [LINES][WORDS_PER_LINE];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WS_BITS-1:0] w_word_sel;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_hit;
  logic               w_rd_req;
  logic               w_latch;
  logic               w_fill;

  assign w_idx      = imem_addr_i[IDX_LSB +: IDX_W];
  assign w_tag      = imem_addr_i[INSTR_SIZE-1:TAG_LSB];
  assign w_word_sel = WS_BITS'((imem_addr_i >> 2) & INSTR_SIZE'(WORDS_PER_LINE - 1));
  assign w_fill_idx = r_mem_addr[IDX_LSB +: IDX_W];
  assign w_fill_tag = r_mem_addr[INSTR_SIZE-1:TAG_LSB];
  assign w_rd_req   = imem_op_en_i && (imem_rd_wr_i == RD);

  icache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tag_array (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_lookup_idx (w_idx),
    .i_lookup_tag (w_tag),
    .o_hit        (w_hit),
    .i_wr_en      (w_fill),
    .i_wr_idx     (w_fill_idx),
    .i_wr_tag     (w_fill_tag),
    .i_flush      (flush_i)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Refill address: captured on the missing cycle, held through REFILL.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
    end else if (w_latch) begin
      r_mem_addr <= imem_addr_i & ~OFS_MASK;
    end
  end

  // Line data: whole line written when the refill completes.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        r_data[w_fill_idx][w] <= mem_rdata_i[w*32 +: 32];
      end
    end
  end

  // Next-state and fetch-side outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_next_state    = r_state;
    imem_miss_o     = 1'b0;
    imem_rd_instr_o = NOP_INSTR;
    w_latch         = 1'b0;
    w_fill          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_req) begin
          if (w_hit) begin
            imem_rd_instr_o = r_data[w_idx][w_word_sel];
          end else begin
            imem_miss_o  = 1'b1;
            w_latch      = 1'b1;
            w_next_state = REFILL;
          end
        end
      end
      REFILL: begin
        imem_miss_o = 1'b1;
        if (mem_ready_i) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign mem_req_o   = (r_state == REFILL);
  assign mem_addr_o  = r_mem_addr;
  assign mem_rd_wr_o = RD;

endmodule

// File: tb/tb_icache_resp.sv
// Directed self-checking bench for icache_resp (4 lines x 4 words).
module tb_icache_resp;
  import icache_resp_pkg::*;

  logic         clk;
  logic         reset_n;
  logic [31:0]  imem_addr_i;
  logic         imem_rd_wr_i;
  logic         imem_op_en_i;
  logic [31:0]  imem_rd_instr_o;
  logic         imem_miss_o;
  logic         flush_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_rd_wr_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A = {32'h0000_0193, 32'h0000_0113, 32'h0000_0093, 32'h0000_0013};
  localparam logic [127:0] LINE_B = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
  localparam logic [127:0] LINE_C = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
  localparam logic [127:0] JUNK   = {4{32'hDEAD_BEEF}};

  icache_resp #(.LINES(4), .WORDS_PER_LINE(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr_i     (imem_addr_i),
    .imem_rd_wr_i    (imem_rd_wr_i),
    .imem_op_en_i    (imem_op_en_i),
    .imem_rd_instr_o (imem_rd_instr_o),
    .imem_miss_o     (imem_miss_o),
    .flush_i         (flush_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rd_wr_o     (mem_rd_wr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects imem_addr_i = a to miss in the current cycle, then runs a refill
  // whose ready pulse arrives in the nreq-th REFILL cycle. The fetch address
  // is scrambled during REFILL and restored to a afterwards.
  task automatic miss_refill(input string tag, input logic [31:0] a,
                             input logic [31:0] exp_line_addr,
                             input logic [127:0] line, input int nreq,
                             input logic flush_at_ready);
    @(negedge clk);
    check({tag, "_miss0"},  {31'd0, imem_miss_o}, 32'd1);
    check({tag, "_instr0"}, imem_rd_instr_o, NOP_INSTR);
    check({tag, "_req0"},   {31'd0, mem_req_o}, 32'd0);
    for (int i = 0; i < nreq; i++) begin
      tick();
      imem_addr_i = a ^ 32'h100;
      if (i == nreq - 1) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = line;
        flush_i     = flush_at_ready;
      end
      @(negedge clk);
      check({tag, "_req"},   {31'd0, mem_req_o}, 32'd1);
      check({tag, "_maddr"}, mem_addr_o, exp_line_addr);
      check({tag, "_miss"},  {31'd0, imem_miss_o}, 32'd1);
      check({tag, "_instr"}, imem_rd_instr_o, NOP_INSTR);
    end
    tick();
    mem_ready_i = 1'b0;
    flush_i     = 1'b0;
    mem_rdata_i = '0;
    imem_addr_i = a;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_instr"}, imem_rd_instr_o, exp);
    check({tag, "_miss"},  {31'd0, imem_miss_o}, 32'd0);
    check({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
  endtask

  logic [31:0] hit_addr [3] = '{32'h44, 32'h48, 32'h4C};
  logic [31:0] hit_data [3] = '{32'h93, 32'h113, 32'h193};

  initial begin
    reset_n      = 1'b0;
    imem_addr_i  = '0;
    imem_rd_wr_i = RD;
    imem_op_en_i = 1'b0;
    flush_i      = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rdata_i  = '0;
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    check("rst_req",   {31'd0, mem_req_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_miss",  {31'd0, imem_miss_o}, 32'd0);
    check("rst_instr", imem_rd_instr_o, NOP_INSTR);
    check("rst_rdwr",  {31'd0, mem_rd_wr_o}, {31'd0, RD});
    tick();
    reset_n = 1'b1;
    tick();

    // Cold miss: 4 stall cycles, then hit on word 0
    imem_addr_i  = 32'h40;
    imem_op_en_i = 1'b1;
    miss_refill("cold", 32'h40, 32'h40, LINE_A, 3, 1'b0);
    expect_hit("cold_hit", 32'h13);

    // Same-line hits on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_addr_i = hit_addr[i];
      expect_hit("line_hit", hit_data[i]);
    end

    // Conflict eviction at index 0 with minimum penalty, then 0x40 misses again
    tick();
    imem_addr_i = 32'h80;
    miss_refill("evict", 32'h80, 32'h80, LINE_B, 1, 1'b0);
    expect_hit("evict_hit", 32'hB000_0000);
    tick();
    imem_addr_i = 32'h8C;
    expect_hit("evict_hit3", 32'hB000_0003);
    tick();
    imem_addr_i = 32'h40;
    miss_refill("remiss", 32'h40, 32'h40, LINE_A, 2, 1'b0);
    expect_hit("remiss_hit", 32'h13);

    // Flush in IDLE: flush cycle still hits, next fetch misses
    tick();
    imem_addr_i = 32'h48;
    flush_i     = 1'b1;
    expect_hit("flush_cyc", 32'h113);
    tick();
    flush_i     = 1'b0;
    imem_addr_i = 32'h40;
    // Refill completes together with a flush: line stays invalid
    miss_refill("flush_miss", 32'h40, 32'h40, LINE_A, 2, 1'b1);
    miss_refill("flush_retry", 32'h40, 32'h40, LINE_A, 1, 1'b0);
    expect_hit("flush_hit", 32'h13);

    // mem_ready_i pulse in IDLE is ignored
    tick();
    imem_op_en_i = 1'b0;
    imem_addr_i  = 32'h50;
    mem_ready_i  = 1'b1;
    mem_rdata_i  = JUNK;
    @(negedge clk);
    check("idle_rdy_miss",  {31'd0, imem_miss_o}, 32'd0);
    check("idle_rdy_instr", imem_rd_instr_o, NOP_INSTR);
    tick();
    mem_ready_i  = 1'b0;
    mem_rdata_i  = '0;
    imem_op_en_i = 1'b1;
    miss_refill("line1", 32'h50, 32'h50, LINE_C, 1, 1'b0);
    expect_hit("line1_hit", 32'hC000_0000);

    // WR request: no miss, NOP, no refill, line untouched
    tick();
    imem_addr_i  = 32'h44;
    imem_rd_wr_i = WR;
    @(negedge clk);
    check("wr_miss",  {31'd0, imem_miss_o}, 32'd0);
    check("wr_instr", imem_rd_instr_o, NOP_INSTR);
    tick();
    imem_addr_i = 32'hA0;
    @(negedge clk);
    check("wr_req",      {31'd0, mem_req_o}, 32'd0);
    check("wr_miss_unc", {31'd0, imem_miss_o}, 32'd0);
    tick();
    imem_rd_wr_i = RD;
    imem_addr_i  = 32'h44;
    expect_hit("after_wr", 32'h93);

    // Reset in the middle of a refill
    tick();
    imem_addr_i = 32'h80;
    @(negedge clk);
    check("mid_miss", {31'd0, imem_miss_o}, 32'd1);
    tick();
    @(negedge clk);
    check("mid_req",   {31'd0, mem_req_o}, 32'd1);
    check("mid_maddr", mem_addr_o, 32'h80);
    reset_n      = 1'b0;
    imem_op_en_i = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_req",   {31'd0, mem_req_o}, 32'd0);
    check("mid_rst_maddr", mem_addr_o, 32'd0);
    check("mid_rst_miss",  {31'd0, imem_miss_o}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    imem_op_en_i = 1'b1;
    imem_addr_i  = 32'h40;
    miss_refill("post_rst", 32'h40, 32'h40, LINE_A, 1, 1'b0);
    expect_hit("post_rst_hit", 32'h13);
    tick();
    imem_addr_i = 32'h54;
    @(negedge clk);
    check("post_rst_l1", {31'd0, imem_miss_o}, 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
